// File: rtl/axi_lite_bw_sequencer_pkg.sv
// Shared types, default widths and arithmetic helpers for the bus bandwidth run sequencer.
package axi_bw_pkg;

  localparam int unsigned RUNS_W = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ERR_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StGap,
    StFinish
  } seq_state_t;

  // Operands and width must stay below 64 bits so the raw sum cannot wrap.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (64'd1 << width) - 64'd1;
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/axi_lite_bw_sequencer_if.sv
// Control, status and master sideband signals of the run sequencer.
interface axi_lite_bw_sequencer_if #(
  parameter int unsigned RUNS_W = axi_bw_pkg::RUNS_W,
  parameter int unsigned CNT_W  = axi_bw_pkg::CNT_W,
  parameter int unsigned ERR_W  = axi_bw_pkg::ERR_W
);
  logic              start;
  logic              abort;
  logic [RUNS_W-1:0] num_runs;
  logic              init_axi_txn;
  logic              txn_done;
  logic              txn_error;
  logic              busy;
  logic              seq_done;
  logic              timeout_flag;
  logic [RUNS_W-1:0] runs_completed;
  logic [ERR_W-1:0]  err_count;
  logic [CNT_W-1:0]  total_cycles;
  logic [CNT_W-1:0]  min_cycles;
  logic [CNT_W-1:0]  max_cycles;

  // The sequencer itself.
  modport slave (
    input  start, abort, num_runs, txn_done, txn_error,
    output init_axi_txn, busy, seq_done, timeout_flag, runs_completed, err_count,
           total_cycles, min_cycles, max_cycles
  );

  // Harness plus AXI-lite master model.
  modport master (
    output start, abort, num_runs, txn_done, txn_error,
    input  init_axi_txn, busy, seq_done, timeout_flag, runs_completed, err_count,
           total_cycles, min_cycles, max_cycles
  );
endinterface

// File: rtl/axi_lite_bw_sequencer_stats.sv
// Per-sequence run statistics: saturating total, min, max and error count.
module bw_run_stats #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [CNT_W-1:0] run_cycles_i,
  input  logic             err_i,
  output logic [CNT_W-1:0] total_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic [ERR_W-1:0] err_count_o
);
  import axi_bw_pkg::*;

  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    total_d = total_q;
    min_d   = min_q;
    max_d   = max_q;
    err_d   = err_q;
    if (clear_i) begin
      total_d = '0;
      min_d   = '1;
      max_d   = '0;
      err_d   = '0;
    end else if (valid_i) begin
      total_d = CNT_W'(sat_add(64'(total_q), 64'(run_cycles_i), CNT_W));
      if (run_cycles_i < min_q) min_d = run_cycles_i;
      if (run_cycles_i > max_q) max_d = run_cycles_i;
      if (err_i) err_d = ERR_W'(sat_add(64'(err_q), 64'd1, ERR_W));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      err_q   <= '0;
    end else begin
      total_q <= total_d;
      min_q   <= min_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  assign total_o     = total_q;
  assign min_o       = min_q;
  assign max_o       = max_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/axi_lite_bw_sequencer.sv
// Launches the AXI-lite traffic master NUM_RUNS times, timing each run up to its done edge.
module axi_lite_bw_sequencer #(
  parameter int unsigned RUNS_W         = 16,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned ERR_W          = 16
) (
  input logic                     ACLK,
  input logic                     ARESET,
  axi_lite_bw_sequencer_if.slave  bus
);
  import axi_bw_pkg::*;

  seq_state_t        state_q, state_d;
  logic              done_q;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [RUNS_W-1:0] rc_q, rc_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [31:0]       gap_q, gap_d;
  logic              abort_q, abort_d;
  logic              tflag_q, tflag_d;

  logic              busy;
  logic              done_edge;
  logic [CNT_W-1:0]  run_cycles;
  logic              stats_clear;
  logic              stats_valid;

  // The master holds TXN_DONE until its next INIT, so only the rising edge marks completion.
  assign done_edge  = bus.txn_done & ~done_q;
  assign run_cycles = cyc_q + CNT_W'(1);
  assign busy       = (state_q == StLaunch) || (state_q == StWait) || (state_q == StGap);

  always_comb begin
    state_d     = state_q;
    runs_d      = runs_q;
    rc_d        = rc_q;
    cyc_d       = cyc_q;
    gap_d       = gap_q;
    abort_d     = abort_q;
    tflag_d     = tflag_q;
    stats_clear = 1'b0;
    stats_valid = 1'b0;
    if (busy && bus.abort) abort_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          runs_d      = bus.num_runs;
          rc_d        = '0;
          tflag_d     = 1'b0;
          stats_clear = 1'b1;
          state_d     = (bus.num_runs == '0) ? StFinish : StLaunch;
        end
      end
      StLaunch: begin
        cyc_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cyc_d = run_cycles;
        if (done_edge) begin
          stats_valid = 1'b1;
          rc_d        = rc_q + RUNS_W'(1);
          // A same-cycle ABORT still ends the sequence at this edge.
          if ((rc_d == runs_q) || abort_q || bus.abort) begin
            state_d = StFinish;
          end else if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = StGap;
          end else begin
            state_d = StLaunch;
          end
        end else if (run_cycles == CNT_W'(TIMEOUT_CYCLES)) begin
          tflag_d = 1'b1;
          state_d = StFinish;
        end
      end
      StGap: begin
        if (gap_q == 32'(GAP_CYCLES - 1)) begin
          state_d = (abort_q || bus.abort) ? StFinish : StLaunch;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (state_d == StIdle) abort_d = 1'b0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      runs_q  <= '0;
      rc_q    <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= bus.txn_done;
      runs_q  <= runs_d;
      rc_q    <= rc_d;
      cyc_q   <= cyc_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
      tflag_q <= tflag_d;
    end
  end

  bw_run_stats #(
    .CNT_W (CNT_W),
    .ERR_W (ERR_W)
  ) u_stats (
    .clk_i        (ACLK),
    .rst_i        (ARESET),
    .clear_i      (stats_clear),
    .valid_i      (stats_valid),
    .run_cycles_i (run_cycles),
    .err_i        (bus.txn_error),
    .total_o      (bus.total_cycles),
    .min_o        (bus.min_cycles),
    .max_o        (bus.max_cycles),
    .err_count_o  (bus.err_count)
  );

  // Gated so a reset arriving during LAUNCH never leaks a launch pulse.
  assign bus.init_axi_txn   = (state_q == StLaunch) && !ARESET;
  assign bus.busy           = busy;
  assign bus.seq_done       = (state_q == StFinish);
  assign bus.timeout_flag   = tflag_q;
  assign bus.runs_completed = rc_q;

endmodule

// File: tb/tb_axi_lite_bw_sequencer.sv
// Directed bench for axi_lite_bw_sequencer with a small AXI-lite master done/error model.
module tb_axi_lite_bw_sequencer;

  typedef struct packed {
    logic [7:0]       runs;
    logic [3:0][7:0]  lat;    // lat[k] is the latency of run k+1 (0 = never done)
    logic [3:0]       err;
    logic [15:0]      e_rc;
    logic [31:0]      e_tot;
    logic [31:0]      e_min;
    logic [31:0]      e_max;
    logic [15:0]      e_err;
    logic             e_to;
    logic [7:0]       e_init;
  } vec_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  axi_lite_bw_sequencer_if bus ();

  axi_lite_bw_sequencer #(
    .RUNS_W         (16),
    .CNT_W          (32),
    .TIMEOUT_CYCLES (64),
    .GAP_CYCLES     (4),
    .ERR_W          (16)
  ) dut (
    .ACLK   (clk),
    .ARESET (areset),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master model: done rises lat cycles after the INIT cycle and holds until the next INIT.
  int mlat [256];
  bit merr [256];
  int mhold [256];
  int m_idx = 0;
  int m_cnt, m_lat, m_hold;
  bit m_err, m_active;

  always @(negedge clk) begin
    if (areset) begin
      bus.txn_done  = 1'b0;
      bus.txn_error = 1'b0;
      m_active      = 1'b0;
    end else if (bus.init_axi_txn) begin
      m_lat    = mlat[m_idx % 256];
      m_err    = merr[m_idx % 256];
      m_hold   = mhold[m_idx % 256];
      m_idx++;
      m_cnt    = 0;
      m_active = 1'b1;
      if (m_hold == 0) begin
        bus.txn_done  = 1'b0;
        bus.txn_error = 1'b0;
      end
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == m_hold) begin
        bus.txn_done  = 1'b0;
        bus.txn_error = 1'b0;
      end
      if (m_lat != 0 && m_cnt == m_lat) begin
        bus.txn_done  = 1'b1;
        bus.txn_error = m_err;
        m_active      = 1'b0;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int s_cyc, d_cyc, ninit;
  logic busy1;
  int ic [16];
  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mkv(input int runs, input int l0, input int l1, input int l2,
                               input int l3, input logic [3:0] em, input int rc,
                               input logic [31:0] tot, input logic [31:0] mn,
                               input logic [31:0] mx, input int er, input logic to,
                               input int ni);
    vec_t v;
    v.runs   = 8'(runs);
    v.lat[0] = 8'(l0);
    v.lat[1] = 8'(l1);
    v.lat[2] = 8'(l2);
    v.lat[3] = 8'(l3);
    v.err    = em;
    v.e_rc   = 16'(rc);
    v.e_tot  = tot;
    v.e_min  = mn;
    v.e_max  = mx;
    v.e_err  = 16'(er);
    v.e_to   = to;
    v.e_init = 8'(ni);
    return v;
  endfunction

  // Program the model for the next 16 runs, repeating the 4-entry latency pattern.
  task automatic prep(input vec_t v, input int hold0);
    for (int k = 0; k < 16; k++) begin
      mlat[(m_idx + k) % 256]  = int'(v.lat[k % 4]);
      merr[(m_idx + k) % 256]  = v.err[k % 4];
      mhold[(m_idx + k) % 256] = (k == 0) ? hold0 : 0;
    end
  endtask

  task automatic run_seq(input int runs, input int ab_init, input int ab_dly,
                         input int rs_init);
    int ab_at;
    int rs_at;
    ab_at = -1;
    rs_at = -1;
    @(negedge clk);
    bus.num_runs = 16'(runs);
    bus.start    = 1'b1;
    s_cyc        = cyc;
    ninit        = 0;
    d_cyc        = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (i == 0) busy1 = bus.busy;
      if (cyc == ab_at) bus.abort = 1'b1;
      if (cyc == rs_at) begin
        bus.start    = 1'b1;
        bus.num_runs = 16'd7;
      end
      if (bus.init_axi_txn) begin
        if (ninit < 16) ic[ninit] = cyc;
        ninit++;
        if (ninit == ab_init) ab_at = cyc + ab_dly;
        if (ninit == rs_init) rs_at = cyc + 3;
      end
      if (bus.seq_done) begin
        d_cyc = cyc;
        break;
      end
    end
    check("seq_done_seen", 64'(d_cyc >= 0), 64'd1);
    @(negedge clk);
    check("seq_done_single_pulse", 64'(bus.seq_done), 64'd0);
    check("busy_after_finish", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_stats(input string tag, input vec_t v);
    check({tag, "_runs_completed"}, 64'(bus.runs_completed), 64'(v.e_rc));
    check({tag, "_total"}, 64'(bus.total_cycles), 64'(v.e_tot));
    check({tag, "_min"}, 64'(bus.min_cycles), 64'(v.e_min));
    check({tag, "_max"}, 64'(bus.max_cycles), 64'(v.e_max));
    check({tag, "_err_count"}, 64'(bus.err_count), 64'(v.e_err));
    check({tag, "_timeout_flag"}, 64'(bus.timeout_flag), 64'(v.e_to));
    check({tag, "_init_pulses"}, 64'(ninit), 64'(v.e_init));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_init"}, 64'(bus.init_axi_txn), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_seq_done"}, 64'(bus.seq_done), 64'd0);
    check({tag, "_timeout"}, 64'(bus.timeout_flag), 64'd0);
    check({tag, "_runs"}, 64'(bus.runs_completed), 64'd0);
    check({tag, "_err"}, 64'(bus.err_count), 64'd0);
    check({tag, "_total"}, 64'(bus.total_cycles), 64'd0);
    check({tag, "_min"}, 64'(bus.min_cycles), 64'd0);
    check({tag, "_max"}, 64'(bus.max_cycles), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int cnt_i, cnt_d;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.num_runs = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 areset = 1'b0;

    vt[0] = mkv(3, 20, 20, 20, 20, 4'b0000, 3, 60, 20, 20, 0, 1'b0, 3);
    vt[1] = mkv(4, 10, 35, 5, 12, 4'b0010, 4, 62, 5, 35, 1, 1'b0, 4);
    vt[2] = mkv(2, 0, 0, 0, 0, 4'b0000, 0, 0, 32'hFFFF_FFFF, 0, 0, 1'b1, 1);
    vt[3] = mkv(0, 9, 9, 9, 9, 4'b0000, 0, 0, 32'hFFFF_FFFF, 0, 0, 1'b0, 0);
    vt[4] = mkv(1, 1, 1, 1, 1, 4'b0001, 1, 1, 1, 1, 1, 1'b0, 1);
    vt[5] = mkv(2, 63, 64, 63, 64, 4'b0000, 2, 127, 63, 64, 0, 1'b0, 2);

    for (int i = 0; i < 6; i++) begin
      prep(vt[i], 0);
      run_seq(int'(vt[i].runs), 0, 0, 0);
      check_stats($sformatf("vec%0d", i), vt[i]);
      check($sformatf("vec%0d_busy_after_start", i), 64'(busy1), 64'(vt[i].runs != 0));
      if (i == 0) begin
        check("vec0_start_to_init", 64'(ic[0] - s_cyc), 64'd1);
        check("vec0_init_spacing_1", 64'(ic[1] - ic[0]), 64'd25);
        check("vec0_init_spacing_2", 64'(ic[2] - ic[1]), 64'd25);
      end
      if (i == 2) check("vec2_timeout_latency", 64'(d_cyc - ic[0]), 64'd65);
      if (i == 3) check("vec3_zero_runs_done", 64'(d_cyc - s_cyc), 64'd1);
    end

    // Done still high from the last run and held past the next INIT: only the re-rise counts.
    v = mkv(1, 15, 15, 15, 15, 4'b0000, 1, 15, 15, 15, 0, 1'b0, 1);
    prep(v, 5);
    run_seq(1, 0, 0, 0);
    check_stats("held_done", v);

    v = mkv(10, 8, 8, 8, 8, 4'b0000, 3, 24, 8, 8, 0, 1'b0, 3);
    prep(v, 0);
    run_seq(10, 3, 3, 0);
    check_stats("abort_mid_run3", v);

    v = mkv(5, 8, 8, 8, 8, 4'b0000, 1, 8, 8, 8, 0, 1'b0, 1);
    prep(v, 0);
    run_seq(5, 1, 8, 0);
    check_stats("abort_at_done_edge", v);

    v = mkv(2, 10, 10, 10, 10, 4'b0000, 2, 20, 10, 10, 0, 1'b0, 2);
    prep(v, 0);
    run_seq(2, 0, 0, 1);
    check_stats("start_while_busy", v);

    // Reset in the middle of run 2.
    v = mkv(3, 20, 20, 20, 20, 4'b0000, 3, 60, 20, 20, 0, 1'b0, 3);
    prep(v, 0);
    @(negedge clk);
    bus.num_runs = 16'd3;
    bus.start    = 1'b1;
    ninit        = 0;
    for (int i = 0; i < 200 && ninit < 2; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.init_axi_txn) ninit++;
    end
    check("rst_second_init_seen", 64'(ninit), 64'd2);
    repeat (5) @(negedge clk);
    #1 areset = 1'b1;
    @(negedge clk);
    check_zero("mid_run_reset");
    #1 areset = 1'b0;
    cnt_i = 0;
    cnt_d = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.init_axi_txn) cnt_i++;
      if (bus.seq_done) cnt_d++;
    end
    check("post_reset_idle_inits", 64'(cnt_i), 64'd0);
    check("post_reset_idle_seq_done", 64'(cnt_d), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
